// File: rtl/arb_req_tracker.sv
// arb_req_tracker: requester-side bookkeeping for a fixed-priority arbiter.
// Holds a saturating outstanding-request counter per port, presents the
// sticky request vector, retires one request per legal one-hot grant and
// flags grant vectors that break the one-hot / requested-port protocol.
// Every output is decoded from registered state, so the arbiter's
// combinational grant never loops back into req_o within a cycle.

// One port's outstanding counter. The push/grant resolution lives here so
// the top only has to fan the legal grant vector out.
module arb_req_lane #(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic gnt,    // already qualified as legal by the top
  output logic req,
  output logic full,
  output logic drop
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  assign req  = (cnt != '0);
  assign full = (cnt == CNT_MAX);

  // Push alone adds one unless saturated, grant alone retires one; a
  // simultaneous push and grant cancel, which lets a full port take a push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      drop <= 1'b0;
    end else begin
      drop <= push & ~gnt & full;
      if (push & ~gnt & ~full)
        cnt <= cnt + CNT_W'(1);
      else if (~push & gnt)
        cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

module arb_req_tracker #(
  parameter int NUM_PORTS = 16,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] push_i,
  output logic [NUM_PORTS-1:0] req_o,
  input  logic [NUM_PORTS-1:0] gnt_i,
  output logic [NUM_PORTS-1:0] full_o,
  output logic [NUM_PORTS-1:0] drop_o,
  output logic                 err_o,
  output logic [NUM_PORTS-1:0] served_o,
  output logic [15:0]          gnt_cnt_o
);
  logic                 gnt_onehot;
  logic                 gnt_hit;
  logic                 gnt_ok;
  logic                 gnt_bad;
  logic [NUM_PORTS-1:0] gnt_legal;

  // Qualify the incoming grant: exactly one bit, landing on a requesting
  // port. Anything else non-zero is discarded whole and reported.
  always_comb begin
    gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - NUM_PORTS'(1))) == '0);
    gnt_hit    = |(gnt_i & req_o);
    gnt_ok     = gnt_onehot & gnt_hit;
    gnt_bad    = (gnt_i != '0) & ~gnt_ok;
    gnt_legal  = gnt_ok ? gnt_i : '0;
  end

  arb_req_lane #(.CNT_W(CNT_W)) u_lane [NUM_PORTS-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_i),
    .gnt     (gnt_legal),
    .req     (req_o),
    .full    (full_o),
    .drop    (drop_o)
  );

  // Grant bookkeeping: sticky error, last served grant, wrapping total.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o     <= 1'b0;
      served_o  <= '0;
      gnt_cnt_o <= '0;
    end else begin
      if (gnt_bad)
        err_o <= 1'b1;
      served_o <= gnt_legal;
      if (gnt_ok)
        gnt_cnt_o <= gnt_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_arb_req_tracker.sv
// Bench for arb_req_tracker: a fixed-priority (lowest index wins) arbiter
// closes the loop by default; tests can override gnt_i with a forced vector.
// A queue-free counter model predicts every output each cycle, and directed
// literal checks pin the model to hand-worked sequences.
module tb_arb_req_tracker;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] push_i = '0;
  logic [NP-1:0] gnt_i;
  logic [NP-1:0] req_o, full_o, drop_o, served_o;
  logic          err_o;
  logic [15:0]   gnt_cnt_o;

  logic          gnt_en = 1'b0;
  logic [NP-1:0] gnt_frc = '0;
  logic [NP-1:0] arb_gnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign arb_gnt = req_o & (~req_o + 16'd1);
  assign gnt_i   = gnt_en ? gnt_frc : arb_gnt;

  arb_req_tracker #(.NUM_PORTS(NP), .CNT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push_i),
    .req_o     (req_o),
    .gnt_i     (gnt_i),
    .full_o    (full_o),
    .drop_o    (drop_o),
    .err_o     (err_o),
    .served_o  (served_o),
    .gnt_cnt_o (gnt_cnt_o)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt [NP];
  logic        m_err = 1'b0;
  logic [15:0] m_served = '0;
  logic [15:0] m_drop = '0;
  logic [15:0] m_gcnt = '0;
  logic [15:0] m_req;
  logic        m_legal;

  initial for (int i = 0; i < NP; i++) m_cnt[i] = 0;

  // Count-based view: a port requests while it owes grants; a grant counts
  // only if it is the single set bit and that port is owed something.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NP; i++) m_cnt[i] = 0;
      m_err = 1'b0; m_served = '0; m_drop = '0; m_gcnt = '0;
    end else begin
      for (int i = 0; i < NP; i++) m_req[i] = (m_cnt[i] > 0);
      m_legal = ($countones(gnt_i) == 1) && ((gnt_i & m_req) != '0);
      if (gnt_i != '0 && !m_legal) m_err = 1'b1;
      for (int i = 0; i < NP; i++) begin
        m_drop[i] = 1'b0;
        if (push_i[i] && !(m_legal && gnt_i[i])) begin
          if (m_cnt[i] == 7) m_drop[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end else if (!push_i[i] && m_legal && gnt_i[i]) begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
      m_served = m_legal ? gnt_i : '0;
      if (m_legal) m_gcnt = m_gcnt + 16'd1;
    end
  end

  logic [15:0] e_req, e_full;

  // Compare every output shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NP; i++) begin
      e_req[i]  = (m_cnt[i] != 0);
      e_full[i] = (m_cnt[i] == 7);
    end
    chk("req_o",     req_o,            e_req);
    chk("full_o",    full_o,           e_full);
    chk("drop_o",    drop_o,           m_drop);
    chk("err_o",     {15'd0, err_o},   {15'd0, m_err});
    chk("served_o",  served_o,         m_served);
    chk("gnt_cnt_o", gnt_cnt_o,        m_gcnt);
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge: hold inputs across one rising edge, then
  // return to idle (no push, arbiter in loop) at the next falling edge.
  task automatic apply(input logic [NP-1:0] p, input logic fen, input logic [NP-1:0] fg);
    push_i = p; gnt_en = fen; gnt_frc = fg;
    @(negedge clk);
    push_i = '0; gnt_en = 1'b0; gnt_frc = '0;
  endtask

  task automatic rst();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst req",    req_o,     16'h0);
    chk("rst err",    {15'd0, err_o}, 16'h0);
    chk("rst gntcnt", gnt_cnt_o, 16'h0);
    reset_n = 1'b1;

    // single request, arbiter in loop
    apply(16'h0004, 1'b0, '0);
    chk("single req", req_o, 16'h0004);
    apply('0, 1'b0, '0);
    chk("single req after", req_o, 16'h0000);
    chk("single served", served_o, 16'h0004);
    chk("single gntcnt", gnt_cnt_o, 16'd1);

    // priority drain
    rst();
    apply(16'h8001, 1'b0, '0);
    chk("drain req0", req_o, 16'h8001);
    apply(16'h0001, 1'b0, '0); chk("drain s1", served_o, 16'h0001);
    apply(16'h0001, 1'b0, '0); chk("drain s2", served_o, 16'h0001);
    apply('0, 1'b0, '0);       chk("drain s3", served_o, 16'h0001);
    apply('0, 1'b0, '0);       chk("drain s4", served_o, 16'h8000);
    apply('0, 1'b0, '0);
    chk("drain gntcnt", gnt_cnt_o, 16'd4);
    chk("drain req end", req_o, 16'h0000);

    // saturation on port 3 with grants held off
    rst();
    for (int k = 1; k <= 8; k++) begin
      apply(16'h0008, 1'b1, '0);
      if (k == 6) chk("sat full6", full_o, 16'h0000);
      if (k == 7) begin
        chk("sat full7", full_o, 16'h0008);
        chk("sat drop7", drop_o, 16'h0000);
      end
    end
    chk("sat drop8", drop_o, 16'h0008);
    apply(16'h0008, 1'b1, 16'h0008);
    chk("sat pg full", full_o, 16'h0008);
    chk("sat pg drop", drop_o, 16'h0000);
    chk("sat pg served", served_o, 16'h0008);

    // multi-hot grant
    rst();
    apply(16'h0003, 1'b0, '0);
    apply('0, 1'b1, 16'h0003);
    chk("mh err", {15'd0, err_o}, 16'h0001);
    chk("mh req", req_o, 16'h0003);
    chk("mh served", served_o, 16'h0000);
    chk("mh gntcnt", gnt_cnt_o, 16'h0000);
    repeat (3) apply('0, 1'b0, '0);
    chk("mh err sticky", {15'd0, err_o}, 16'h0001);
    chk("mh drained", req_o, 16'h0000);

    // grant to idle port
    rst();
    chk("err cleared", {15'd0, err_o}, 16'h0000);
    apply('0, 1'b1, 16'h0010);
    chk("idle err", {15'd0, err_o}, 16'h0001);
    chk("idle gntcnt", gnt_cnt_o, 16'h0000);

    // reset mid-operation
    rst();
    repeat (3) apply(16'h0202, 1'b1, '0);
    apply('0, 1'b1, '0);
    chk("mid req", req_o, 16'h0202);
    #2 reset_n = 1'b0;
    #1;
    chk("mid async req",  req_o,     16'h0000);
    chk("mid async full", full_o,    16'h0000);
    chk("mid async srv",  served_o,  16'h0000);
    chk("mid async cnt",  gnt_cnt_o, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    apply(16'h0200, 1'b0, '0);
    repeat (4) apply('0, 1'b0, '0);
    chk("mid one grant", gnt_cnt_o, 16'd1);
    chk("mid req end", req_o, 16'h0000);

    // grant counter wrap
    rst();
    apply(16'h0001, 1'b0, '0);
    for (int k = 0; k < 65535; k++) apply(16'h0001, 1'b0, '0);
    chk("wrap ffff", gnt_cnt_o, 16'hFFFF);
    apply('0, 1'b0, '0);
    chk("wrap zero", gnt_cnt_o, 16'h0000);
    chk("wrap err", {15'd0, err_o}, 16'h0000);
    chk("wrap req", req_o, 16'h0000);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/arb_req_tracker.md
# arb_req_tracker

Requester-side companion to the `day14` fixed-priority arbiter. It accepts request pushes from NUM_PORTS clients and keeps a per-port count of outstanding requests. It drives the sticky `req_o` vector into the arbiter and retires one request per legal one-hot grant returned on `gnt_i`. It also checks the arbiter's grants against the protocol, flags violations, and keeps a running count of served grants.

## Interface
- NUM_PORTS, 16, number of client/arbiter ports.
- CNT_W, 3, width of each per-port outstanding counter; maximum depth per port is 2^CNT_W-1 (7).
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- push_i  input  NUM_PORTS  bit i high adds one outstanding request to port i this cycle.
- req_o  output  NUM_PORTS  to arbiter `req_i`; bit i = (cnt[i] != 0); decoded from registered state only.
- gnt_i  input  NUM_PORTS  from arbiter `gnt_o`; combinational response to `req_o` in the same cycle.
- full_o  output  NUM_PORTS  bit i = (cnt[i] == 2^CNT_W-1); decoded from registered state.
- drop_o  output  NUM_PORTS  registered one-cycle pulse: a push to port i was discarded in the previous cycle.
- err_o  output  1  sticky protocol-error flag; cleared only by reset.
- served_o  output  NUM_PORTS  registered copy of the legal grant accepted in the previous cycle.
- gnt_cnt_o  output  16  total legal grants accepted; wraps from 0xFFFF to 0x0000.

## Operation
- A grant vector is legal when it is one-hot and its set bit k satisfies `req_o[k]` = 1. An all-zero vector is legal and idle.
- Illegal grant vectors:
  - More than one bit set: the whole vector is ignored and no counter decrements.
  - A single bit set on a port with `req_o` low: the grant is ignored.
  - In both cases `err_o` is set on the next edge.
- Per-port update, computed every cycle for each i:
  - g = legal grant on port i; p = `push_i[i]`.
  - p=1, g=0, not full: cnt+1.
  - p=0, g=1: cnt-1.
  - p=1, g=1: cnt unchanged. The push is accepted, because the grant frees a slot even when the port is full.
  - p=1, g=0, full: cnt unchanged. The push is discarded and `drop_o[i]` = 1 on the next cycle.
  - p=0, g=0: cnt unchanged.
- Counters never wrap or go negative. Decrement happens only on legal grants, which imply cnt > 0.
- `served_o` <= legal grant vector, or zero when the grant is illegal or idle.
- `gnt_cnt_o` increments by 1 on every legal non-zero grant.
- Pushes on any subset of ports in the same cycle are handled independently.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Outstanding requests are lost, and `req_o` drops in the same cycle without waiting for a clock edge.

## Timing
- Reset values: `req_o`=0, `full_o`=0, `drop_o`=0, `err_o`=0, `served_o`=0, `gnt_cnt_o`=0, all counters 0.
- Push at edge N leads to `req_o[i]` high after edge N+1, i.e. one cycle of latency.
- The grant seen in cycle N, combinational from `req_o`, is consumed at edge N+1.
  - If cnt was 1, `req_o[i]` is low after N+1. The arbiter therefore never sees a stale request for a retired grant.
- `drop_o`, `served_o`, `err_o` and `gnt_cnt_o` all update at the edge following the triggering cycle.
- Reset release: first state update on the first rising edge with `reset_n`=1.
- No combinational path from `push_i` or `gnt_i` to any output. This rules out a combinational loop with the arbiter.

## Test plan
- Single request, day14 bench wiring, NUM_PORTS=16, arbiter in loop:
  - Stimulus: push `push_i`=0x0004 for one cycle.
  - Required: `req_o`=0x0004 the next cycle; `gnt_i`=0x0004; after the following edge `req_o`=0, `served_o`=0x0004, `gnt_cnt_o`=1.
- Priority drain:
  - Stimulus: push 0x8001 once, then 0x0001 twice more.
  - Required: port 0 is served 3 times, then port 15 once; `served_o` sequence 0x0001, 0x0001, 0x0001, 0x8000; `gnt_cnt_o`=4; `req_o`=0 at end.
- Saturation:
  - Stimulus: 8 consecutive pushes on port 3 with `gnt_i` forced to 0.
  - Required: `full_o[3]`=1 after the 7th push; `drop_o`=0x0008 one cycle after the 8th push.
  - Then push and grant port 3 in the same cycle: count stays 7 and no drop occurs.
- Protocol errors with forced `gnt_i`:
  - `gnt_i`=0x0003 with both ports requesting: no decrement, `err_o`=1.
  - After reset, `gnt_i`=0x0010 with `req_o`=0: `err_o`=1 and `gnt_cnt_o` stays 0.
  - `err_o` remains high until reset.
- Reset mid-operation:
  - Stimulus: load ports 1 and 9 with 3 requests each; drop `reset_n` between clock edges.
  - Required: `req_o` goes to 0 immediately and all outputs take their reset values.
  - After release, a single push on port 9 yields exactly one grant.
- Counter wrap:
  - Stimulus: 65536 legal grants.
  - Required: `gnt_cnt_o` returns to 0x0000 and no error is raised.
